// File: rtl/baccarat_match_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : baccarat_match_ctrl                                        |
// | Description : Sequences a multi-round baccarat match. Each card load     |
// |               waits on a card-source handshake. The dealer third-card    |
// |               rule is selectable. The block keeps registered             |
// |               win/loss/tie tallies and a completed-hand counter.         |
// |                                                                          |
// | Parameters  : NUM_ROUNDS  - hands per match (1 .. 2**CNT_W-1)            |
// |               CNT_W       - width of round index and tally counters      |
// |               DEALER_RULE - 0: full tableau, 1: dealer draws on <= 5     |
// |                                                                          |
// | Ports       : slow_clock        in   clock, state changes on falling edge|
// |               resetb            in   async active-low reset              |
// |               card_valid        in   card source has a card ready        |
// |               next_round        in   level, leaves ROUND_END             |
// |               pscore/dscore     in   4b hand scores (0..9)               |
// |               pcard3            in   4b player third-card face value     |
// |               load_[pd]card[123] out per-card load strobes (Mealy)       |
// |               clear_hands       out  clears all six card registers       |
// |               player/dealer_win_light out registered result, both = tie  |
// |               player_wins, dealer_wins, ties out saturating tallies      |
// |               round_idx         out  number of hands completed           |
// |               match_done        out  match over                          |
// |                                                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module baccarat_match_ctrl #(
  parameter int NUM_ROUNDS  = 5,
  parameter int CNT_W       = 4,
  parameter int DEALER_RULE = 0
) (
  input  logic             slow_clock,
  input  logic             resetb,
  input  logic             card_valid,
  input  logic             next_round,
  input  logic [3:0]       pscore,
  input  logic [3:0]       dscore,
  input  logic [3:0]       pcard3,
  output logic             load_pcard1,
  output logic             load_pcard2,
  output logic             load_pcard3,
  output logic             load_dcard1,
  output logic             load_dcard2,
  output logic             load_dcard3,
  output logic             clear_hands,
  output logic             player_win_light,
  output logic             dealer_win_light,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties,
  output logic [CNT_W-1:0] round_idx,
  output logic             match_done
);

  typedef enum logic [3:0] {
    S_CLR       = 4'd0,
    S_P1        = 4'd1,
    S_D1        = 4'd2,
    S_P2        = 4'd3,
    S_D2        = 4'd4,
    S_CHECK     = 4'd5,
    S_P3        = 4'd6,
    S_D3CHK     = 4'd7,
    S_D3        = 4'd8,
    S_SCORE     = 4'd9,
    S_ROUND_END = 4'd10,
    S_MATCH_END = 4'd11
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_LAST_ROUND = CNT_W'(NUM_ROUNDS);

  // Registered state
  state_t           state_q,     state_d;
  logic             stood_q,     stood_d;
  logic             pwin_q,      pwin_d;
  logic             dwin_q,      dwin_d;
  logic [CNT_W-1:0] pwins_q,     pwins_d;
  logic [CNT_W-1:0] dwins_q,     dwins_d;
  logic [CNT_W-1:0] ties_q,      ties_d;
  logic [CNT_W-1:0] round_q,     round_d;
  logic             done_q,      done_d;

  // Combinational helpers
  logic             w_natural;
  logic             w_tableau_draw;
  logic             w_dealer_draw;
  logic [CNT_W-1:0] w_round_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == C_CNT_MAX) ? v : v + C_CNT_ONE;
  endfunction

  assign w_natural = (pscore == 4'd8) || (pscore == 4'd9) ||
                     (dscore == 4'd8) || (dscore == 4'd9);

  // Classic dealer tableau, used only when the player took a third card.
  always_comb begin
    w_tableau_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: w_tableau_draw = 1'b1;
      4'd3:             w_tableau_draw = (pcard3 != 4'd8);
      4'd4:             w_tableau_draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
      4'd5:             w_tableau_draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
      4'd6:             w_tableau_draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
      default:          w_tableau_draw = 1'b0;
    endcase
  end

  // A standing player, or the simplified rule, reduces the dealer decision
  // to a plain threshold on the dealer score.
  assign w_dealer_draw = (stood_q || (DEALER_RULE == 1)) ? (dscore <= 4'd5)
                                                         : w_tableau_draw;

  assign w_round_inc = round_q + C_CNT_ONE;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    stood_d = stood_q;
    pwin_d  = pwin_q;
    dwin_d  = dwin_q;
    pwins_d = pwins_q;
    dwins_d = dwins_q;
    ties_d  = ties_q;
    round_d = round_q;
    done_d  = done_q;

    case (state_q)
      S_CLR: begin
        pwin_d  = 1'b0;
        dwin_d  = 1'b0;
        stood_d = 1'b0;
        state_d = S_P1;
      end
      S_P1:    if (card_valid) state_d = S_D1;
      S_D1:    if (card_valid) state_d = S_P2;
      S_P2:    if (card_valid) state_d = S_D2;
      S_D2:    if (card_valid) state_d = S_CHECK;
      S_CHECK: begin
        if (w_natural) begin
          state_d = S_SCORE;
        end else if (pscore <= 4'd5) begin
          state_d = S_P3;
        end else begin
          // 6, 7 and out-of-range scores all make the player stand.
          stood_d = 1'b1;
          state_d = S_D3CHK;
        end
      end
      S_P3:    if (card_valid) state_d = S_D3CHK;
      S_D3CHK: state_d = w_dealer_draw ? S_D3 : S_SCORE;
      S_D3:    if (card_valid) state_d = S_SCORE;
      S_SCORE: begin
        pwin_d = (pscore >= dscore);
        dwin_d = (pscore <= dscore);
        if (pscore > dscore) begin
          pwins_d = sat_inc(pwins_q);
        end else if (pscore < dscore) begin
          dwins_d = sat_inc(dwins_q);
        end else begin
          ties_d = sat_inc(ties_q);
        end
        round_d = w_round_inc;
        if (w_round_inc == C_LAST_ROUND) begin
          done_d  = 1'b1;
          state_d = S_MATCH_END;
        end else begin
          state_d = S_ROUND_END;
        end
      end
      S_ROUND_END: if (next_round) state_d = S_CLR;
      S_MATCH_END: state_d = S_MATCH_END;
      default:     state_d = S_CLR;
    endcase
  end

  always_ff @(negedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_CLR;
      stood_q <= 1'b0;
      pwin_q  <= 1'b0;
      dwin_q  <= 1'b0;
      pwins_q <= '0;
      dwins_q <= '0;
      ties_q  <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stood_q <= stood_d;
      pwin_q  <= pwin_d;
      dwin_q  <= dwin_d;
      pwins_q <= pwins_d;
      dwins_q <= dwins_d;
      ties_q  <= ties_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  // Load strobes follow card_valid directly so a card is consumed in the
  // same cycle the source offers it.
  assign load_pcard1 = (state_q == S_P1) && card_valid;
  assign load_dcard1 = (state_q == S_D1) && card_valid;
  assign load_pcard2 = (state_q == S_P2) && card_valid;
  assign load_dcard2 = (state_q == S_D2) && card_valid;
  assign load_pcard3 = (state_q == S_P3) && card_valid;
  assign load_dcard3 = (state_q == S_D3) && card_valid;

  // Held off while reset is asserted so the card registers are cleared on
  // the first cycle after release rather than during reset.
  assign clear_hands = (state_q == S_CLR) && resetb;

  assign player_win_light = pwin_q;
  assign dealer_win_light = dwin_q;
  assign player_wins      = pwins_q;
  assign dealer_wins      = dwins_q;
  assign ties             = ties_q;
  assign round_idx        = round_q;
  assign match_done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_baccarat_match_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_baccarat_match_ctrl                                     |
// | Description : Self-checking bench for baccarat_match_ctrl. Two instances |
// |               (tableau rule and simplified dealer rule, 3-hand matches)  |
// |               share stimulus; the unused one is held in reset. Expected  |
// |               strobe sequences and results come from a hand-level model. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_baccarat_match_ctrl;

  localparam int NR = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [5:0] SP1 = 6'b000001, SD1 = 6'b000010, SP2 = 6'b000100,
                         SD2 = 6'b001000, SP3 = 6'b010000, SD3 = 6'b100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstb0, rstb1, card_valid, next_round;
  logic [3:0] pscore, dscore, pcard3;

  // strobe vector bit order: {d3, p3, d2, p2, d1, p1}
  logic [5:0] strb0, strb1;
  logic clr0, clr1, pl0, pl1, dl0, dl1, done0, done1;
  logic [CW-1:0] pw0, dw0, ti0, ri0, pw1, dw1, ti1, ri1;

  baccarat_match_ctrl #(.NUM_ROUNDS(NR), .CNT_W(CW), .DEALER_RULE(0)) dut0 (
    .slow_clock(clk), .resetb(rstb0), .card_valid(card_valid), .next_round(next_round),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(strb0[0]), .load_dcard1(strb0[1]), .load_pcard2(strb0[2]),
    .load_dcard2(strb0[3]), .load_pcard3(strb0[4]), .load_dcard3(strb0[5]),
    .clear_hands(clr0), .player_win_light(pl0), .dealer_win_light(dl0),
    .player_wins(pw0), .dealer_wins(dw0), .ties(ti0), .round_idx(ri0), .match_done(done0));

  baccarat_match_ctrl #(.NUM_ROUNDS(NR), .CNT_W(CW), .DEALER_RULE(1)) dut1 (
    .slow_clock(clk), .resetb(rstb1), .card_valid(card_valid), .next_round(next_round),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .load_pcard1(strb1[0]), .load_dcard1(strb1[1]), .load_pcard2(strb1[2]),
    .load_dcard2(strb1[3]), .load_pcard3(strb1[4]), .load_dcard3(strb1[5]),
    .clear_hands(clr1), .player_win_light(pl1), .dealer_win_light(dl1),
    .player_wins(pw1), .dealer_wins(dw1), .ties(ti1), .round_idx(ri1), .match_done(done1));

  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 0;

  // observed view of the selected instance
  logic [5:0] o_strb;
  logic o_clr, o_pl, o_dl, o_done;
  logic [CW-1:0] o_pw, o_dw, o_ti, o_ri;
  always_comb begin
    o_strb = (sel == 1) ? strb1 : strb0;
    o_clr  = (sel == 1) ? clr1  : clr0;
    o_pl   = (sel == 1) ? pl1   : pl0;
    o_dl   = (sel == 1) ? dl1   : dl0;
    o_done = (sel == 1) ? done1 : done0;
    o_pw   = (sel == 1) ? pw1   : pw0;
    o_dw   = (sel == 1) ? dw1   : dw0;
    o_ti   = (sel == 1) ? ti1   : ti0;
    o_ri   = (sel == 1) ? ri1   : ri0;
  end

  // reference model state, per instance
  int m_pw[2], m_dw[2], m_ti[2], m_rounds[2];
  bit m_pl, m_dl;

  function automatic bit tableau(input int ds, input int pc3);
    case (ds)
      0, 1, 2: return 1'b1;
      3:       return pc3 != 8;
      4:       return (pc3 >= 2) && (pc3 <= 7);
      5:       return (pc3 >= 4) && (pc3 <= 7);
      6:       return (pc3 >= 6) && (pc3 <= 7);
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset(input int which);
    rstb0 = 1'b0; rstb1 = 1'b0; card_valid = 1'b0; next_round = 1'b0;
    repeat (3) @(posedge clk);
    sel = which;
    m_pw[which] = 0; m_dw[which] = 0; m_ti[which] = 0; m_rounds[which] = 0;
    m_pl = 1'b0; m_dl = 1'b0;
    if (which == 1) rstb1 = 1'b1; else rstb0 = 1'b1;
  endtask

  task automatic pulse_next();
    next_round = 1'b1;
    @(posedge clk);
    next_round = 1'b0;
  endtask

  // Plays one hand on the selected instance starting in CLR.
  // mode 0: card_valid tied high, 1: random card_valid, 2: 5-cycle stall in D1.
  task automatic run_hand(input int ps, input int ds, input int pc3, input int mode,
                          input int abort_at, output bit aborted);
    logic [5:0] q[$];
    bit nat, drew, ddraw, cv, done;
    int lat, cyc, stall, target;
    aborted = 1'b0; drew = 1'b0; ddraw = 1'b0; done = 1'b0; stall = 0; cyc = 0;
    pscore = 4'(ps); dscore = 4'(ds); pcard3 = 4'(pc3);
    nat = (ps == 8) || (ps == 9) || (ds == 8) || (ds == 9);
    q = {SP1, SD1, SP2, SD2};
    if (!nat) begin
      drew = (ps <= 5);
      if (drew) q.push_back(SP3);
      ddraw = (!drew || sel == 1) ? (ds <= 5) : tableau(ds, pc3);
      if (ddraw) q.push_back(SD3);
    end
    lat = 7 + (nat ? 0 : 1 + int'(drew) + int'(ddraw));
    target = m_rounds[sel] + 1;
    while (!done && cyc < 400) begin
      case (mode)
        0: cv = 1'b1;
        1: cv = ($urandom_range(0, 2) != 0);
        default: begin
          if (stall > 0) begin cv = 1'b0; stall--; end else cv = 1'b1;
        end
      endcase
      card_valid = cv;
      #1;
      if (cyc == 0) begin
        n_tests++;
        if (o_clr !== 1'b1) begin n_fail++; $display("FAIL clear_first: got %b want 1", o_clr); end
      end else begin
        n_tests++;
        if (o_clr !== 1'b0) begin n_fail++; $display("FAIL clear_extra cyc %0d: got %b want 0", cyc, o_clr); end
      end
      n_tests++;
      if ($countones(o_strb) > 1) begin
        n_fail++; $display("FAIL strobe_onehot cyc %0d: got %b want at most one", cyc, o_strb);
      end else if (o_strb !== 6'b0) begin
        if (!cv) begin
          n_fail++; $display("FAIL strobe_no_valid cyc %0d: got %b want 000000", cyc, o_strb);
        end else if (q.size() == 0) begin
          n_fail++; $display("FAIL strobe_extra cyc %0d: got %b want 000000", cyc, o_strb);
        end else begin
          if (o_strb !== q[0]) begin
            n_fail++; $display("FAIL strobe_order cyc %0d: got %b want %b", cyc, o_strb, q[0]);
          end
          if (mode == 2 && q[0] == SP1) stall = 5;
          void'(q.pop_front());
        end
      end
      if (cyc == abort_at) begin
        aborted = 1'b1;
        return;
      end
      if (o_ri === CW'(target)) begin
        done = 1'b1;
      end else if (cyc >= 1) begin
        n_tests++;
        if ({o_pl, o_dl} !== 2'b00) begin
          n_fail++; $display("FAIL lights_midhand cyc %0d: got %b want 00", cyc, {o_pl, o_dl});
        end
        n_tests++;
        if ({o_pw, o_dw, o_ti, o_ri} !== {CW'(m_pw[sel]), CW'(m_dw[sel]), CW'(m_ti[sel]), CW'(m_rounds[sel])}) begin
          n_fail++; $display("FAIL counters_midhand cyc %0d: got %h want %h", cyc, {o_pw, o_dw, o_ti, o_ri},
                             {CW'(m_pw[sel]), CW'(m_dw[sel]), CW'(m_ti[sel]), CW'(m_rounds[sel])});
        end
      end
      if (!done) begin
        @(posedge clk);
        cyc++;
      end
    end
    n_tests++;
    if (!done) begin
      n_fail++; $display("FAIL hand_timeout: round_idx got %0d want %0d", o_ri, target);
    end else begin
      m_rounds[sel] = target;
      if (ps > ds)      m_pw[sel] = (m_pw[sel] < CMAX) ? m_pw[sel] + 1 : CMAX;
      else if (ps < ds) m_dw[sel] = (m_dw[sel] < CMAX) ? m_dw[sel] + 1 : CMAX;
      else              m_ti[sel] = (m_ti[sel] < CMAX) ? m_ti[sel] + 1 : CMAX;
      m_pl = (ps >= ds); m_dl = (ps <= ds);
      if (mode == 0) begin
        n_tests++;
        if (cyc != lat) begin n_fail++; $display("FAIL hand_latency: got %0d want %0d", cyc, lat); end
      end
      n_tests++;
      if (q.size() != 0) begin n_fail++; $display("FAIL strobe_missing: got %0d left want 0", q.size()); end
      n_tests++;
      if ({o_pl, o_dl} !== {m_pl, m_dl}) begin
        n_fail++; $display("FAIL lights: got %b want %b", {o_pl, o_dl}, {m_pl, m_dl});
      end
      n_tests++;
      if ({o_pw, o_dw, o_ti} !== {CW'(m_pw[sel]), CW'(m_dw[sel]), CW'(m_ti[sel])}) begin
        n_fail++; $display("FAIL tallies: got %h want %h", {o_pw, o_dw, o_ti},
                           {CW'(m_pw[sel]), CW'(m_dw[sel]), CW'(m_ti[sel])});
      end
      n_tests++;
      if (o_done !== (m_rounds[sel] == NR)) begin
        n_fail++; $display("FAIL match_done: got %b want %b", o_done, (m_rounds[sel] == NR));
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rstb0 = 1'b0; rstb1 = 1'b0; card_valid = 1'b1; next_round = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({strb0, clr0, pl0, dl0, done0} !== 10'b0) begin
      n_fail++; $display("FAIL reset_bits0: got %b want 0", {strb0, clr0, pl0, dl0, done0});
    end
    n_tests++;
    if ({pw0, dw0, ti0, ri0} !== '0) begin
      n_fail++; $display("FAIL reset_counters0: got %h want 0", {pw0, dw0, ti0, ri0});
    end
    n_tests++;
    if ({strb1, clr1, pl1, dl1, done1, pw1, dw1, ti1, ri1} !== '0) begin
      n_fail++; $display("FAIL reset_all1: got %h want 0", {strb1, clr1, pl1, dl1, done1, pw1, dw1, ti1, ri1});
    end
    next_round = 1'b0;
  endtask

  task automatic test_natural();
    bit ab;
    do_reset(0);
    run_hand(9, 3, 0, 0, -1, ab);
  endtask

  task automatic test_tableau();
    bit ab;
    do_reset(0);
    run_hand(4, 6, 7, 0, -1, ab);
    pulse_next();
    run_hand(4, 6, 8, 0, -1, ab);
    pulse_next();
    run_hand(2, 3, 8, 0, -1, ab);
  endtask

  task automatic test_player_stands();
    bit ab;
    do_reset(0);
    run_hand(6, 5, 0, 0, -1, ab);
    pulse_next();
    run_hand(6, 6, 0, 0, -1, ab);
    pulse_next();
    run_hand(7, 2, 0, 1, -1, ab);
  endtask

  task automatic test_stall();
    bit ab;
    do_reset(0);
    run_hand(5, 2, 4, 2, -1, ab);
  endtask

  task automatic test_match_length();
    bit ab;
    do_reset(0);
    for (int h = 0; h < NR; h++) begin
      run_hand($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 9), 1, -1, ab);
      if (h < NR - 1) begin
        repeat (3) begin
          card_valid = 1'b1; #1;
          n_tests++;
          if ({o_strb, o_clr} !== 7'b0) begin
            n_fail++; $display("FAIL round_end_idle: got %b want 0", {o_strb, o_clr});
          end
          n_tests++;
          if ({o_pl, o_dl} !== {m_pl, m_dl}) begin
            n_fail++; $display("FAIL round_end_lights: got %b want %b", {o_pl, o_dl}, {m_pl, m_dl});
          end
          @(posedge clk);
        end
        pulse_next();
      end
    end
    next_round = 1'b1; card_valid = 1'b1;
    repeat (4) begin
      #1;
      n_tests++;
      if ({o_done, o_clr, o_strb} !== 8'b1000_0000) begin
        n_fail++; $display("FAIL match_end_hold: got %b want 10000000", {o_done, o_clr, o_strb});
      end
      n_tests++;
      if ({o_ri, o_pl, o_dl} !== {CW'(NR), m_pl, m_dl}) begin
        n_fail++; $display("FAIL match_end_state: got %h want %h", {o_ri, o_pl, o_dl}, {CW'(NR), m_pl, m_dl});
      end
      @(posedge clk);
    end
    next_round = 1'b0;
  endtask

  task automatic test_reset_mid_match();
    bit ab;
    do_reset(0);
    run_hand($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), 1, -1, ab);
    pulse_next();
    run_hand(6, 4, 0, 0, 6, ab);
    n_tests++;
    if (!ab) begin n_fail++; $display("FAIL abort_point: got %b want 1", ab); end
    rstb0 = 1'b0; #1;
    n_tests++;
    if ({strb0, clr0, pl0, dl0, done0, pw0, dw0, ti0, ri0} !== '0) begin
      n_fail++; $display("FAIL midmatch_reset: got %h want 0", {strb0, clr0, pl0, dl0, done0, pw0, dw0, ti0, ri0});
    end
    repeat (2) @(posedge clk);
    m_pw[0] = 0; m_dw[0] = 0; m_ti[0] = 0; m_rounds[0] = 0;
    rstb0 = 1'b1;
    run_hand(3, 7, 1, 0, -1, ab);
  endtask

  task automatic test_dealer_rule1();
    bit ab;
    do_reset(1);
    run_hand(4, 6, 6, 0, -1, ab);
    pulse_next();
    run_hand(4, 5, 8, 0, -1, ab);
    pulse_next();
    run_hand($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), 1, -1, ab);
  endtask

  task automatic test_random();
    bit ab;
    repeat (6) begin
      do_reset($urandom_range(0, 1));
      for (int h = 0; h < NR; h++) begin
        run_hand($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 9),
                 $urandom_range(0, 1), -1, ab);
        if (h < NR - 1) pulse_next();
      end
    end
  endtask

  initial begin
    rstb0 = 1'b0; rstb1 = 1'b0; card_valid = 1'b0; next_round = 1'b0;
    pscore = 4'd0; dscore = 4'd0; pcard3 = 4'd0;
    test_reset();
    test_natural();
    test_tableau();
    test_player_stands();
    test_stall();
    test_match_length();
    test_reset_mid_match();
    test_dealer_rule1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
